// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the pipelined LEGv8 CPU.
// Holds the PC register and the IF/ID pipeline register. It selects the next PC
// (PC+4, hold, or branch target) and hands a registered {pc, instr, valid}
// bundle to decode, honouring stall from hazard detection and flush/redirect
// from branch resolution.

// Generic 2:1 select cell, used to build the next-PC choice.
module fetch_mux2 #(
  parameter int W = 64
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

module fetch_stage #(
  parameter int                  ADDR_W    = 64,
  parameter int                  INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'hD503201F
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active-low
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [31:0]        fetch_count
);

  // BOOT spends the first edge after reset release doing nothing, so the
  // instruction memory sees a stable RESET_PC for a full cycle before capture.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_ifid_pc;
  logic [INSTR_W-1:0]  r_ifid_instr;
  logic                r_ifid_valid;
  logic [31:0]         r_fetch_count;

  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [ADDR_W-1:0]   w_target_aligned;
  logic                w_advance;
  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_pc_next;
  logic                w_capture;
  logic                w_bubble;
  logic                w_count_sat;

  // Sequential successor wraps modulo 2^ADDR_W; no overflow flag is kept.
  assign w_pc_plus4       = r_pc + PC_STEP;
  // Word alignment: the low two bits of a redirect are discarded.
  assign w_target_aligned = br_target & ALIGN_MASK;

  // PC advances only on a plain capture; flush and stall both hold it.
  assign w_advance = ~flush & ~stall;

  // First select cell: hold the current PC or step to PC+4.
  fetch_mux2 #(.W(ADDR_W)) u_seq_mux (
    .i_sel (w_advance),
    .i_d0  (r_pc),
    .i_d1  (w_pc_plus4),
    .o_y   (w_pc_seq)
  );

  // Second select cell: a taken branch overrides everything else.
  fetch_mux2 #(.W(ADDR_W)) u_redirect_mux (
    .i_sel (br_taken),
    .i_d0  (w_pc_seq),
    .i_d1  (w_target_aligned),
    .o_y   (w_pc_next)
  );

  // Priority decode of the RUN-state action: redirect > flush > stall > capture.
  assign w_bubble    = br_taken | flush;
  assign w_capture   = ~br_taken & ~flush & ~stall;
  assign w_count_sat = &r_fetch_count;

  // FSM, PC register, IF/ID register and capture counter, all updated together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_ifid_pc     <= '0;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          // Control inputs are ignored here; everything holds for one edge.
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          r_pc <= w_pc_next;
          if (w_bubble) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end else if (w_capture) begin
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= imem_rdata;
            r_ifid_valid <= 1'b1;
            // Saturating counter: it sticks at all-ones instead of wrapping.
            if (!w_count_sat) begin
              r_fetch_count <= r_fetch_count + 32'd1;
            end
          end
          // Stall alone: IF/ID and counter hold (PC holds via the select cells).
        end

        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // The instruction memory address is the PC register only, never the
  // redirect target, so there is no combinational path from br_target.
  assign imem_addr   = r_pc;
  assign ifid_pc     = r_ifid_pc;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_valid  = r_ifid_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps with a reference model of
// PC/count and a scoreboard of expected IF/ID captures.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic        m_boot;
  logic [63:0] m_pc;
  logic [31:0] m_count;
  logic        m_valid;
  logic        m_new;
  fetch_t      m_hold;
  fetch_t      sb_q[$];

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_valid  (ifid_valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [63:0] a);
    return 32'h8B020020 + a[31:0];
  endfunction

  // Combinational instruction memory.
  assign imem_rdata = instr_at(imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = '0;
    m_count = '0;
    m_valid = 1'b0;
    m_new   = 1'b0;
    sb_q.delete();
  endtask

  // Predict from the inputs being driven, wait one edge, compare.
  task automatic tick(input string tag);
    fetch_t e;
    m_new = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (br_taken) begin
      m_pc    = {br_target[63:2], 2'b00};
      m_valid = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      sb_q.push_back('{pc: m_pc, instr: instr_at(m_pc)});
      m_pc    = m_pc + 64'd4;
      m_valid = 1'b1;
      m_new   = 1'b1;
      if (m_count != 32'hFFFFFFFF) m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    check({tag, ".pc"},    imem_addr,   m_pc);
    check({tag, ".count"}, {32'd0, fetch_count}, {32'd0, m_count});
    check({tag, ".valid"}, {63'd0, ifid_valid},  {63'd0, m_valid});
    if (m_new) begin
      if (sb_q.size() == 0) begin
        check({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        m_hold = e;
      end
    end
    if (m_valid) begin
      check({tag, ".ifid_pc"},    ifid_pc,              m_hold.pc);
      check({tag, ".ifid_instr"}, {32'd0, ifid_instr},  {32'd0, m_hold.instr});
    end else begin
      check({tag, ".bub_pc"},    ifid_pc,             64'd0);
      check({tag, ".bub_instr"}, {32'd0, ifid_instr}, {32'd0, NOP});
    end
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = '0;
  endtask

  initial begin
    model_reset();

    // 1. Reset for 3 cycles, then BOOT edge, then first capture.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.addr",  imem_addr, 64'd0);
      check("rst.valid", {63'd0, ifid_valid}, 64'd0);
      check("rst.count", {32'd0, fetch_count}, 64'd0);
    end
    reset = 1'b1;
    stall = 1'b1; flush = 1'b1; br_taken = 1'b1; br_target = 64'h40;  // ignored in BOOT
    tick("boot");
    check("boot.addr", imem_addr, 64'd0);
    clear_ctrl();
    tick("first");
    check("first.instr", {32'd0, ifid_instr}, 64'h8B020020);
    check("first.addr",  imem_addr, 64'd4);
    check("first.count", {32'd0, fetch_count}, 64'd1);

    // 2. Sequential fetch up to pc=8.
    tick("seq");
    check("seq.ifid_pc", ifid_pc, 64'd4);

    // 3. Stall two cycles at pc=8, then release.
    stall = 1'b1;
    tick("stall1");
    tick("stall2");
    check("stall.pc",    imem_addr, 64'd8);
    check("stall.ifid",  ifid_pc,   64'd4);
    check("stall.count", {32'd0, fetch_count}, 64'd2);
    stall = 1'b0;
    tick("unstall");
    check("unstall.ifid", ifid_pc,   64'd8);
    check("unstall.pc",   imem_addr, 64'd12);

    // 4. Branch with simultaneous stall; target low bits are dropped.
    br_taken = 1'b1; br_target = 64'h103; stall = 1'b1;
    tick("br");
    check("br.pc",    imem_addr, 64'h100);
    check("br.instr", {32'd0, ifid_instr}, {32'd0, NOP});
    clear_ctrl();
    tick("br_next");
    check("br_next.ifid", ifid_pc, 64'h100);

    // 5. Redirect to 20, then flush there with stall also asserted.
    br_taken = 1'b1; br_target = 64'd20;
    tick("to20");
    clear_ctrl();
    flush = 1'b1; stall = 1'b1;
    tick("flush");
    check("flush.pc", imem_addr, 64'd20);
    clear_ctrl();
    tick("refetch");
    check("refetch.ifid", ifid_pc, 64'd20);

    // Several plain sequential cycles.
    for (int i = 0; i < 5; i++) tick("run");

    // 6a. PC wrap at the top of the address space.
    br_taken = 1'b1; br_target = 64'hFFFFFFFFFFFFFFFF;
    tick("wrap_br");
    check("wrap_br.pc", imem_addr, 64'hFFFFFFFFFFFFFFFC);
    clear_ctrl();
    tick("wrap");
    check("wrap.pc",   imem_addr, 64'd0);
    check("wrap.ifid", ifid_pc,   64'hFFFFFFFFFFFFFFFC);

    // 6b. Counter saturation.
    @(negedge clk);
    force dut.r_fetch_count = 32'hFFFFFFFE;
    #1;
    release dut.r_fetch_count;
    m_count = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++) tick("sat");
    check("sat.count", {32'd0, fetch_count}, 64'h00000000FFFFFFFF);

    // 6c. Asynchronous reset mid-cycle while clk is high.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst.addr",  imem_addr, 64'd0);
    check("arst.valid", {63'd0, ifid_valid}, 64'd0);
    check("arst.instr", {32'd0, ifid_instr}, {32'd0, NOP});
    check("arst.ifpc",  ifid_pc, 64'd0);
    check("arst.count", {32'd0, fetch_count}, 64'd0);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    tick("reboot");
    tick("refirst");
    check("refirst.instr", {32'd0, ifid_instr}, 64'h8B020020);
    check("end.sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined LEGv8 CPU.
- Holds the PC register and the IF/ID pipeline register.
- Owns the next-PC choice: PC+4 versus the branch target. The choice is built from 2:1 select cells driven by `br_taken`.
- Consumes the branch-resolution signals. Produces a registered `{pc, instr, valid}` bundle for decode. Honours stall from hazard detection and flush from branch resolution.

Parameters:
- `ADDR_W`, 64: PC and address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset; must be a multiple of 4.
- `NOP_INSTR`, 32'hD503201F: encoding inserted into IF/ID on a bubble.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `stall`  input  1  hazard unit: hold PC and IF/ID this cycle.
- `flush`  input  1  kill the instruction entering IF/ID this cycle.
- `br_taken`  input  1  branch resolved taken: redirect PC.
- `br_target`  input  ADDR_W  redirect address.
- `imem_addr`  output  ADDR_W  instruction memory address; equals the PC register.
- `imem_rdata`  input  INSTR_W  instruction memory read data; combinational from `imem_addr`, same cycle.
- `ifid_pc`  output  ADDR_W  PC of the instruction held in IF/ID.
- `ifid_instr`  output  INSTR_W  instruction held in IF/ID.
- `ifid_valid`  output  1  IF/ID holds a real instruction.
- `fetch_count`  output  32  number of instructions captured into IF/ID with valid=1.

Behaviour:
- **Reset** (`reset`=0, asynchronous, takes effect immediately):
  - `pc` = `RESET_PC`
  - `ifid_pc` = 0
  - `ifid_instr` = `NOP_INSTR`
  - `ifid_valid` = 0
  - `fetch_count` = 0
  - state = BOOT
- **State machine** (2 states):
  - BOOT: first rising edge after reset release. No capture, `pc` holds, IF/ID stays a bubble, `fetch_count` holds. Go to RUN unconditionally. `stall`, `flush` and `br_taken` are ignored in BOOT.
  - RUN: steady state. Each rising edge is evaluated in the priority order below.
- **RUN update priority** (highest first):
  1. `br_taken`=1:
     - `pc` <= `br_target` with bits [1:0] forced to 0.
     - IF/ID <= bubble (`valid`=0, `instr`=`NOP_INSTR`, `pc`=0).
     - Overrides `stall` and `flush`.
  2. `flush`=1 (no `br_taken`):
     - IF/ID <= bubble.
     - `pc` holds, so the same address is refetched next cycle.
     - Overrides `stall`.
  3. `stall`=1: `pc`, IF/ID and `fetch_count` all hold their values.
  4. Otherwise:
     - `ifid_pc` <= `pc`, `ifid_instr` <= `imem_rdata`, `ifid_valid` <= 1.
     - `pc` <= `pc` + 4.
- **Latency:** the instruction at address A, presented on `imem_rdata` while `pc`=A, appears on the `ifid_*` outputs one cycle later.
- **Arithmetic:** `pc`+4 is modulo 2^`ADDR_W`; all-ones-minus-3 wraps to 0 with no flag.
- **`fetch_count`:**
  - Increments by 1 only on a case-4 capture.
  - Saturates at 32'hFFFFFFFF and never wraps.
- **`imem_addr`** is purely the PC register. No combinational path exists from `br_target` to `imem_addr`.
- **Reset mid-operation:** asserting `reset` in any state immediately forces the reset values, discarding any pending redirect or stall.

Test Plan:
1. Reset and boot:
   - Stimulus: hold `reset`=0 for 3 cycles, release; `imem_rdata` = 32'h8B020020.
   - Required: during reset and the BOOT edge, `imem_addr`=0 and `ifid_valid`=0. After the second edge, `ifid_pc`=0, `ifid_instr`=32'h8B020020, `ifid_valid`=1, `imem_addr`=4, `fetch_count`=1.
2. Sequential fetch:
   - Stimulus: run 5 RUN cycles, no control inputs.
   - Required: `imem_addr` steps 0, 4, 8, 12, 16; `fetch_count`=5; `ifid_pc` trails `imem_addr` by one cycle.
3. Stall:
   - Stimulus: at `pc`=8, assert `stall` for 2 cycles.
   - Required: `pc`=8, `ifid_pc`=4 and `fetch_count` are unchanged for both cycles. Release `stall` → next edge `ifid_pc`=8, `pc`=12.
4. Branch redirect with stall:
   - Stimulus: at `pc`=12, `br_taken`=1, `br_target`=64'h103, `stall`=1 in the same cycle.
   - Required: after the edge, `pc`=64'h100, `ifid_valid`=0, `ifid_instr`=`NOP_INSTR`. The next free edge yields `ifid_pc`=64'h100.
5. Flush only:
   - Stimulus: at `pc`=20, `flush`=1.
   - Required: `ifid_valid`=0 and `pc` stays 20. The next edge captures `ifid_pc`=20.
6. Boundaries:
   - Wrap: with `br_target`=64'hFFFFFFFFFFFFFFFC followed by one capture → `pc`=0.
   - Saturation: preload `fetch_count` to 32'hFFFFFFFE (via force) and do 3 captures → count reads 32'hFFFFFFFF.
   - Async reset: assert `reset` mid-cycle → outputs reset immediately, without waiting for an edge.
